// File: rtl/pcm_status_poll_pkg.sv
// Shared definitions for the PCM status-poll stage and the unlock/program
// sequencer: command opcodes, status-register bit indices, FSM state and
// bus-phase encodings, and the SR error classifier.
package pcm_status_poll_pkg;

  localparam logic [15:0] CMD_UNLOCK1 = 16'h0060;
  localparam logic [15:0] CMD_UNLOCK2 = 16'h00D0;
  localparam logic [15:0] CMD_PROG    = 16'h0040;
  localparam logic [15:0] CMD_RDSR    = 16'h0070;
  localparam logic [15:0] CMD_CLRSR   = 16'h0050;
  localparam logic [15:0] CMD_RDARR   = 16'h00FF;

  // Status register bit indices
  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPP_ERR   = 3;
  localparam int SR_LOCK_ERR  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_WR,
    ST_REC,
    ST_RD,
    ST_CHECK,
    ST_CLR_WR,
    ST_RDA_WR,
    ST_DONE
  } state_t;

  // Kind of bus activity the bus-cycle engine is performing
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_WR,
    PH_RD,
    PH_GAP
  } phase_t;

  function automatic logic sr_error(input logic [7:0] sr);
    return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
  endfunction

endpackage

// File: rtl/pcm_status_poll_bus_cycle.sv
// One timed PCM bus phase: registered active-low strobes, dq drive enable,
// write data and a down-counter for the phase length.
// Ports:
//   clk, rst        clock, async active-high reset
//   load            start a new phase this edge (phase/wdata valid)
//   phase           phase to enter when load=1
//   wdata           data to drive for a write phase
//   ce, oe, we      PCM strobes, active-low, registered
//   dq_oe, dq_out   write data bus drive enable and data
//   last            current phase is on its final cycle
//   sample          final cycle of a read phase (capture dq_in now)
module pcm_status_poll_bus_cycle
  import pcm_status_poll_pkg::*;
#(
  parameter int WR_TIME = 5,
  parameter int RD_TIME = 10,
  parameter int CMD_GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  phase_t      phase,
  input  logic [15:0] wdata,
  output logic        ce,
  output logic        oe,
  output logic        we,
  output logic        dq_oe,
  output logic [15:0] dq_out,
  output logic        last,
  output logic        sample
);

  localparam int CW = 16;
  localparam logic [CW-1:0] WR_LOAD  = CW'(WR_TIME - 1);
  localparam logic [CW-1:0] RD_LOAD  = CW'(RD_TIME - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(CMD_GAP - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  phase_t        phase_q, phase_d;
  logic          ce_q, ce_d, oe_q, oe_d, we_q, we_d, dq_oe_q, dq_oe_d;
  logic [15:0]   dq_out_q, dq_out_d;

  always_comb begin
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    ce_d     = ce_q;
    oe_d     = oe_q;
    we_d     = we_q;
    dq_oe_d  = dq_oe_q;
    dq_out_d = dq_out_q;
    if (load) begin
      phase_d = phase;
      ce_d    = 1'b1;
      oe_d    = 1'b1;
      we_d    = 1'b1;
      unique case (phase)
        PH_WR: begin
          cnt_d    = WR_LOAD;
          ce_d     = 1'b0;
          we_d     = 1'b0;
          dq_oe_d  = 1'b1;
          dq_out_d = wdata;
        end
        PH_RD: begin
          cnt_d   = RD_LOAD;
          ce_d    = 1'b0;
          oe_d    = 1'b0;
          dq_oe_d = 1'b0;
        end
        // Recovery keeps dq driven after a write (hold time), released after a read
        PH_GAP: cnt_d = GAP_LOAD;
        default: begin
          cnt_d   = '0;
          dq_oe_d = 1'b0;
        end
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      phase_q  <= PH_IDLE;
      ce_q     <= 1'b1;
      oe_q     <= 1'b1;
      we_q     <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign ce     = ce_q;
  assign oe     = oe_q;
  assign we     = we_q;
  assign dq_oe  = dq_oe_q;
  assign dq_out = dq_out_q;
  assign last   = (cnt_q == '0);
  assign sample = (phase_q == PH_RD) && (cnt_q == '0);

endmodule

// File: rtl/pcm_status_poll.sv
// PCM status poll: after a program operation, issues Read Status (0x70),
// polls SR7 until ready, classifies the error bits, clears status (0x50) on
// error and reports the result with a one-cycle done pulse.
// Optional feature macro: PCM_RDARRAY_EN -- on clean completion, write Read
// Array (0xFF) before done so the device returns to array mode.
// Ports:
//   clk, rst        clock, async active-high reset
//   start           1-cycle request, accepted only when idle
//   base_addr       word address [24:1] of the programmed block
//   busy, done      sequence in progress / 1-cycle completion pulse
//   status          last sampled SR[7:0]
//   err, timeout    error bits seen / POLL_MAX reads without ready
//   ce, oe, we      PCM strobes (active-low), addr PCM word address
//   dq_out, dq_oe   write data and its drive enable; dq_in read data
module pcm_status_poll
  import pcm_status_poll_pkg::*;
#(
  parameter int WR_TIME  = 5,
  parameter int RD_TIME  = 10,
  parameter int CMD_GAP  = 1,
  parameter int POLL_MAX = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  status,
  output logic        err,
  output logic        timeout,
  output logic        ce,
  output logic        oe,
  output logic        we,
  output logic [23:0] addr,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  input  logic [15:0] dq_in
);

  localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;       // state that follows the current recovery gap
  logic [23:0] addr_q, addr_d;
  logic [7:0]  status_q, status_d;
  logic [15:0] poll_q, poll_d;
  logic        err_q, err_d, timeout_q, timeout_d, busy_q, busy_d, done_q, done_d;

  logic        bus_load, bus_last, bus_sample;
  phase_t      bus_phase;
  logic [15:0] bus_wdata;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    addr_d    = addr_q;
    status_d  = status_q;
    poll_d    = poll_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_CMD_WR;
        ret_d     = ST_RD;
        addr_d    = base_addr;
        poll_d    = '0;
        err_d     = 1'b0;
        timeout_d = 1'b0;
      end
      ST_CMD_WR, ST_CLR_WR, ST_RDA_WR: if (bus_last) state_d = ST_REC;
      ST_REC: if (bus_last) state_d = ret_q;
      ST_RD: if (bus_sample) begin
        status_d = dq_in[7:0];
        poll_d   = poll_q + 16'd1;
        state_d  = ST_REC;
        ret_d    = ST_CHECK;
      end
      ST_CHECK: begin
        if (status_q[SR_READY] && sr_error(status_q)) begin
          state_d = ST_CLR_WR;
          ret_d   = ST_DONE;
          err_d   = 1'b1;
        end else if (status_q[SR_READY]) begin
`ifdef PCM_RDARRAY_EN
          state_d = ST_RDA_WR;
          ret_d   = ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end else if (poll_q == POLL_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          // Device is still in status mode, so just read again
          state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;  // ST_DONE
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Bus strobes are registered from the next state so they line up with it
  always_comb begin
    bus_load  = (state_d != state_q);
    bus_phase = PH_IDLE;
    bus_wdata = CMD_RDSR;
    unique case (state_d)
      ST_CMD_WR: bus_phase = PH_WR;
      ST_CLR_WR: begin bus_phase = PH_WR; bus_wdata = CMD_CLRSR; end
      ST_RDA_WR: begin bus_phase = PH_WR; bus_wdata = CMD_RDARR; end
      ST_RD:     bus_phase = PH_RD;
      ST_REC:    bus_phase = PH_GAP;
      default:   bus_phase = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      addr_q    <= '0;
      status_q  <= '0;
      poll_q    <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      addr_q    <= addr_d;
      status_q  <= status_d;
      poll_q    <= poll_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  pcm_status_poll_bus_cycle #(
    .WR_TIME(WR_TIME),
    .RD_TIME(RD_TIME),
    .CMD_GAP(CMD_GAP)
  ) u_bus (
    .clk   (clk),
    .rst   (rst),
    .load  (bus_load),
    .phase (bus_phase),
    .wdata (bus_wdata),
    .ce    (ce),
    .oe    (oe),
    .we    (we),
    .dq_oe (dq_oe),
    .dq_out(dq_out),
    .last  (bus_last),
    .sample(bus_sample)
  );

  assign addr    = addr_q;
  assign status  = status_q;
  assign err     = err_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pcm_status_poll.sv
module tb_pcm_status_poll;

  localparam int WR_T = 5, RD_T = 10, GAP = 1, PMAX = 4;
`ifdef PCM_RDARRAY_EN
  localparam bit RDA = 1'b1;
`else
  localparam bit RDA = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] base_addr = '0;
  logic        busy, done, err, timeout, ce, oe, we, dq_oe;
  logic [7:0]  status;
  logic [23:0] addr;
  logic [15:0] dq_out;
  logic [15:0] dq_in = 16'h0000;

  always #5 clk = ~clk;

  pcm_status_poll #(.WR_TIME(WR_T), .RD_TIME(RD_T), .CMD_GAP(GAP), .POLL_MAX(PMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
    .status(status), .err(err), .timeout(timeout), .ce(ce), .oe(oe), .we(we), .addr(addr),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
  );

  typedef struct {
    string       name;
    logic [7:0]  status;
    logic        err;
    logic        timeout;
    int          lat;
    int          n_rd;
    int          n70;
    int          n50;
    int          nff;
    logic [15:0] last_op;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  resp[$];
  logic [23:0] cur_addr = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Device model + bus monitor + scoreboard checker
  int          t0 = 0, wr_len = 0, rd_len = 0, n_rd = 0, n70 = 0, n50 = 0, nff = 0, bad = 0;
  logic [15:0] last_op = '0;
  logic        busy_prev = 1'b0, we_prev = 1'b1, oe_prev = 1'b1;

  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      t0 = cyc; n_rd = 0; n70 = 0; n50 = 0; nff = 0; bad = 0; last_op = '0; wr_len = 0; rd_len = 0;
    end
    if (!we) wr_len++;
    else if (!we_prev) begin
      if (wr_len != WR_T) bad++;
      last_op = dq_out;
      case (dq_out)
        16'h0070: n70++;
        16'h0050: n50++;
        16'h00FF: nff++;
        default:  bad++;
      endcase
      wr_len = 0;
    end
    if (!oe) begin
      if (oe_prev) begin
        n_rd++;
        // upper byte is junk so the DUT must only use dq_in[7:0]
        if (resp.size() > 1) dq_in = {8'hA5, resp.pop_front()};
        else if (resp.size() == 1) dq_in = {8'hA5, resp[0]};
      end
      rd_len++;
    end else if (!oe_prev) begin
      if (rd_len != RD_T) bad++;
      rd_len = 0;
    end
    if (!oe && dq_oe) bad++;
    if (!oe && !we) bad++;
    if (!ce && addr !== cur_addr) bad++;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no completion pending");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        $display("txn %s: status=0x%02h err=%0b timeout=%0b latency=%0d reads=%0d w70=%0d w50=%0d wff=%0d",
                 e.name, status, err, timeout, cyc - t0 + 1, n_rd, n70, n50, nff);
        chk({e.name, "_status"}, 32'(status), 32'(e.status));
        chk({e.name, "_err"}, 32'(err), 32'(e.err));
        chk({e.name, "_timeout"}, 32'(timeout), 32'(e.timeout));
        chk({e.name, "_latency"}, 32'(cyc - t0 + 1), 32'(e.lat));
        chk({e.name, "_reads"}, 32'(n_rd), 32'(e.n_rd));
        chk({e.name, "_wr70"}, 32'(n70), 32'(e.n70));
        chk({e.name, "_wr50"}, 32'(n50), 32'(e.n50));
        chk({e.name, "_wrff"}, 32'(nff), 32'(e.nff));
        chk({e.name, "_last_op"}, 32'(last_op), 32'(e.last_op));
        chk({e.name, "_bus_timing"}, 32'(bad), 32'd0);
      end
    end
    busy_prev = busy; we_prev = we; oe_prev = oe;
  end

  // lat_base: latency without any Read Array write
  task automatic push(input string nm, input logic [7:0] st, input bit e, input bit to,
                      input int lat_base, input int nrd, input int w50, input bit rda_path);
    exp_t x;
    x.name = nm; x.status = st; x.err = e; x.timeout = to; x.n_rd = nrd; x.n70 = 1; x.n50 = w50;
    x.nff = (rda_path && RDA) ? 1 : 0;
    x.lat = lat_base + ((rda_path && RDA) ? (WR_T + GAP) : 0);
    x.last_op = (w50 != 0) ? 16'h0050 : ((x.nff != 0) ? 16'h00FF : 16'h0070);
    sbq.push_back(x);
  endtask

  task automatic pulse_start(input logic [23:0] a);
    @(negedge clk);
    base_addr = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 400);
    chk({nm, "_completes"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_strobes", {29'd0, ce, oe, we}, 32'h7);
    chk("reset_dq", {15'd0, dq_oe, dq_out}, 32'h0);
    chk("reset_addr", 32'(addr), 32'h0);
    chk("reset_outs", {20'd0, busy, done, err, timeout, status}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1: ready on first read
    resp = {8'h80}; cur_addr = 24'h012345;
    push("t1_ready", 8'h80, 0, 0, 19, 1, 0, 1);
    pulse_start(cur_addr); wait_idle("t1");

    // T2: three busy reads then ready; 0x70 issued once
    resp = {8'h00, 8'h00, 8'h00, 8'h80}; cur_addr = 24'hABCDEF;
    push("t2_poll", 8'h80, 0, 0, 55, 4, 0, 1);
    pulse_start(cur_addr); wait_idle("t2");

    // T3: SR4 program error -> clear status
    resp = {8'h90}; cur_addr = 24'h000100;
    push("t3_sr4", 8'h90, 1, 0, 19 + WR_T + GAP, 1, 1, 0);
    pulse_start(cur_addr); wait_idle("t3");

    // T4: never ready -> timeout after PMAX reads
    resp = {8'h00}; cur_addr = 24'hFFFFFF;
    push("t4_timeout", 8'h00, 0, 1, 19 + (PMAX - 1) * 12, PMAX, 0, 0);
    pulse_start(cur_addr); wait_idle("t4");

    // Error bit SR1 on second read, SR6 alone is not an error, SR5 error
    resp = {8'h00, 8'h82}; cur_addr = 24'h5A5A5A;
    push("t7_sr1", 8'h82, 1, 0, 19 + 12 + WR_T + GAP, 2, 1, 0);
    pulse_start(cur_addr); wait_idle("t7");
    resp = {8'hC0}; cur_addr = 24'h000001;
    push("t8_sr6", 8'hC0, 0, 0, 19, 1, 0, 1);
    pulse_start(cur_addr); wait_idle("t8");
    resp = {8'hA0}; cur_addr = 24'h800000;
    push("t9_sr5", 8'hA0, 1, 0, 19 + WR_T + GAP, 1, 1, 0);
    pulse_start(cur_addr); wait_idle("t9");

    // T5: asynchronous reset during the read phase
    resp = {8'h00}; cur_addr = 24'h123456;
    pulse_start(cur_addr);
    begin
      int k;
      k = 0;
      while (oe && k < 100) begin @(negedge clk); k++; end
      chk("t5_reached_rd", 32'(oe), 32'd0);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_strobes", {29'd0, ce, oe, we}, 32'h7);
    chk("t5_async_dq_oe", 32'(dq_oe), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    resp = {8'h80}; cur_addr = 24'h0F0F0F;
    push("t5_after_rst", 8'h80, 0, 0, 19, 1, 0, 1);
    pulse_start(cur_addr); wait_idle("t5");

    // T6: start while busy is ignored; addr stays at first base_addr
    resp = {8'h80}; cur_addr = 24'h246800;
    push("t6_busy_start", 8'h80, 0, 0, 19, 1, 0, 1);
    pulse_start(cur_addr);
    repeat (4) @(negedge clk);
    pulse_start(24'h999999);
    wait_idle("t6");
    repeat (30) @(negedge clk);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
